lagarto_plic_gateway_bank: RTL and testbench
============================================

LAGARTO_PLIC_GATEWAY_BANK -- requirements
Module: lagarto_plic_gateway_bank

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 8: number of interrupt sources (1..1023).
REQ-002 SHALL have parameter MAX_PENDING, default 7: edge-mode pending-count saturation value (>=1).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth (>=2).
REQ-004 SHALL have port clk_i, input, 1: single clock, all logic rising-edge.
REQ-005 SHALL have port rstn_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port interrupt_signal_i, input, NUM_SOURCES: raw asynchronous source lines.
REQ-007 SHALL have port edge_mode_i, input, NUM_SOURCES: per source, 1 = edge-triggered, 0 = level-triggered.
REQ-008 SHALL have port interrupt_claim_i, input, NUM_SOURCES: one-cycle claim pulse per source.
REQ-009 SHALL have port interrupt_complete_i, input, NUM_SOURCES: one-cycle completion pulse per source.
REQ-010 SHALL have port interrupt_request_o, output, NUM_SOURCES: registered request towards the PLIC core.
REQ-011 SHALL have port pending_overflow_o, output, NUM_SOURCES: one-cycle pulse when an edge is dropped at saturation.

Function
REQ-012 Each source SHALL pass through a SYNC_STAGES flop synchroniser; "sync" means the last synchroniser stage below.
REQ-013 Edge detection SHALL be sync=1 and the previous-cycle sync=0.
REQ-014 Each source SHALL run an FSM with states IDLE, REQUEST, IN_SERVICE.
REQ-015 interrupt_request_o[i] SHALL be 1 exactly while source i is in REQUEST.
REQ-016 The mode SHALL be sampled from edge_mode_i[i] only while in IDLE; the mode is held constant outside IDLE.
REQ-017 Level, IDLE: if sync=1, go to REQUEST next cycle (sampled-to-request latency 1 cycle).
REQ-018 Edge, IDLE: if the counter >0 or an edge is detected, go to REQUEST next cycle.
REQ-019 REQUEST: on claim, go to IN_SERVICE; otherwise stay, even if a level source deasserts.
REQ-020 IN_SERVICE: on complete, go to REQUEST if (level and sync=1) or (edge and (counter >0 or edge this cycle)); otherwise go to IDLE.
REQ-021 A claim outside REQUEST SHALL be ignored.
REQ-022 A complete outside IN_SERVICE SHALL be ignored, including a complete coinciding with a claim in REQUEST.
REQ-023 Edge counter width SHALL be $clog2(MAX_PENDING+1).
REQ-024 Edge counter increment: each detected edge adds 1.
REQ-025 Edge counter decrement: each claim accepted in REQUEST subtracts 1.
REQ-026 A simultaneous edge and accepted claim SHALL leave the counter unchanged.
REQ-027 An edge arriving at counter=MAX_PENDING (with no simultaneous claim) SHALL be dropped, and pending_overflow_o[i] SHALL pulse for 1 cycle.
REQ-028 The counter SHALL never wrap.
REQ-029 In level mode the counter SHALL be held at 0.
REQ-030 Sources SHALL be fully independent; simultaneous events on different sources SHALL not interact.

Reset
REQ-031 On rstn_i=0, all FSMs SHALL go to IDLE immediately.
REQ-032 On rstn_i=0, counters, synchroniser flops, edge-history flops and latched modes SHALL go to 0.
REQ-033 On rstn_i=0, interrupt_request_o and pending_overflow_o SHALL go to 0.
REQ-034 Reset asserted mid-service SHALL discard all pending and in-service state.
REQ-035 After rstn_i deasserts, the first request SHALL appear no earlier than SYNC_STAGES+1 cycles after the source asserts.

Structure
REQ-036 lagarto_plic_pkg SHALL hold the gateway state enum (IDLE, REQUEST, IN_SERVICE).
REQ-037 lagarto_plic_pkg SHALL hold the trigger-mode constants and default parameter constants.
REQ-038 The per-source logic (synchroniser, edge detector, counter, FSM) SHALL be sub-module lagarto_plic_gateway_cell, instantiated NUM_SOURCES times by generate.
REQ-039 There SHALL be no latches and no combinational path from any input to any output.

Verification
REQ-040 Level: hold src0=1 -> req0=1 at cycle SYNC_STAGES+1; claim -> req0=0 next cycle; complete with src0 still 1 -> req0=1 next cycle; complete with src0=0 -> IDLE, req0 stays 0.
REQ-041 Edge: 3 pulses on src1 before claim -> req1=1; three claim/complete rounds each re-raise req1; after the third, req1=0 and counter=0.
REQ-042 Saturation: MAX_PENDING=7, 9 edges without claim -> counter=7, pending_overflow_o[1] pulses on the 8th and 9th edges; the counter holds 7.
REQ-043 Simultaneous events: an edge in the same cycle as the accepted claim -> counter unchanged; a claim+complete in the same cycle in REQUEST -> IN_SERVICE, complete ignored.
REQ-044 Reset mid-operation: src2 in IN_SERVICE with counter=4, assert rstn_i=0 -> req2=0 and counter=0 asynchronously; after release with no edges, req2 stays 0.
REQ-045 Mode and independence: toggling edge_mode_i[3] while in IN_SERVICE has no effect until IDLE; concurrent activity on all NUM_SOURCES=8 sources produces no cross-source interaction.

Source files
------------

// File: rtl/lagarto_plic_pkg.sv
// Shared definitions for the PLIC gateway bank.
// Contents: the per-source gateway state encoding, the trigger-mode values
// carried on edge_mode_i, and the default parameter values used by the bank.
package lagarto_plic_pkg;

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_REQUEST    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_e;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    localparam int DEFAULT_NUM_SOURCES = 8;
    localparam int DEFAULT_MAX_PENDING = 7;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/lagarto_plic_gateway_cell.sv
// One interrupt gateway: input synchroniser, rising-edge detector,
// saturating pending counter (edge mode) and the request/service FSM.
//
// state         | meaning
// --------------+--------------------------------------------------------
// GW_IDLE       | nothing pending; trigger mode follows edge_mode_i
// GW_REQUEST    | request_o high, waiting for the core to claim
// GW_IN_SERVICE | claimed, waiting for complete; mode frozen
//
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   src_i          raw asynchronous interrupt line
//   edge_mode_i    1 = edge-triggered, 0 = level-triggered
//   claim_i        claim pulse (honoured only in GW_REQUEST)
//   complete_i     completion pulse (honoured only in GW_IN_SERVICE)
//   request_o      registered request, high exactly in GW_REQUEST
//   overflow_o     one-cycle pulse when an edge is dropped at saturation
module lagarto_plic_gateway_cell
    import lagarto_plic_pkg::*;
#(
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic src_i,
    input  logic edge_mode_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic request_o,
    output logic overflow_o
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   mode_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    gw_state_e              state_q, state_d;

    logic sync;
    logic edge_det;
    logic mode_eff;
    logic claim_acc;
    logic pending;

    assign sync      = sync_q[SYNC_STAGES-1];
    assign edge_det  = sync & ~prev_q;
    // The live mode input only matters while idle; otherwise the copy taken
    // on the last idle cycle is used so a request/service round is stable.
    assign mode_eff  = (state_q == GW_IDLE) ? edge_mode_i : mode_q;
    assign claim_acc = (state_q == GW_REQUEST) & claim_i;
    assign pending   = (cnt_q != '0) | edge_det;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (mode_eff == MODE_LEVEL) begin
            cnt_d = '0;
        end else if (edge_det && !claim_acc) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!edge_det && claim_acc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GW_IDLE: begin
                if ((mode_eff == MODE_LEVEL) ? sync : pending) begin
                    state_d = GW_REQUEST;
                end
            end
            GW_REQUEST: begin
                if (claim_i) begin
                    state_d = GW_IN_SERVICE;
                end
            end
            GW_IN_SERVICE: begin
                if (complete_i) begin
                    if ((mode_eff == MODE_LEVEL) ? sync : pending) begin
                        state_d = GW_REQUEST;
                    end else begin
                        state_d = GW_IDLE;
                    end
                end
            end
            default: state_d = GW_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            mode_q  <= MODE_LEVEL;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= GW_IDLE;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], src_i};
            prev_q  <= sync;
            mode_q  <= mode_eff;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign request_o  = (state_q == GW_REQUEST);
    assign overflow_o = ovf_q;

endmodule

// File: rtl/lagarto_plic_gateway_bank.sv
// Bank of independent PLIC interrupt gateways, one cell per source.
// Ports (all NUM_SOURCES wide except clock/reset):
//   clk_i, rstn_i           clock, asynchronous active-low reset
//   interrupt_signal_i      raw asynchronous source lines
//   edge_mode_i             per-source trigger mode (1 = edge)
//   interrupt_claim_i       per-source claim pulse from the core
//   interrupt_complete_i    per-source completion pulse from the core
//   interrupt_request_o     registered request towards the core
//   pending_overflow_o      pulse when an edge is lost at saturation
module lagarto_plic_gateway_bank
    import lagarto_plic_pkg::*;
#(
    parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NUM_SOURCES-1:0] interrupt_signal_i,
    input  logic [NUM_SOURCES-1:0] edge_mode_i,
    input  logic [NUM_SOURCES-1:0] interrupt_claim_i,
    input  logic [NUM_SOURCES-1:0] interrupt_complete_i,
    output logic [NUM_SOURCES-1:0] interrupt_request_o,
    output logic [NUM_SOURCES-1:0] pending_overflow_o
);

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
        lagarto_plic_gateway_cell #(
            .MAX_PENDING (MAX_PENDING),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cell (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .src_i       (interrupt_signal_i[i]),
            .edge_mode_i (edge_mode_i[i]),
            .claim_i     (interrupt_claim_i[i]),
            .complete_i  (interrupt_complete_i[i]),
            .request_o   (interrupt_request_o[i]),
            .overflow_o  (pending_overflow_o[i])
        );
    end

endmodule

// File: tb/tb_lagarto_plic_gateway_bank.sv
module tb_lagarto_plic_gateway_bank;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] src, mode, claim, cmpl;
    logic [7:0] req, ovf;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       ov;
    logic [8:0] ov_seen;

    always #5 clk = ~clk;

    lagarto_plic_gateway_bank #(
        .NUM_SOURCES (8),
        .MAX_PENDING (7),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .interrupt_signal_i   (src),
        .edge_mode_i          (mode),
        .interrupt_claim_i    (claim),
        .interrupt_complete_i (cmpl),
        .interrupt_request_o  (req),
        .pending_overflow_o   (ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle pulse; returns the overflow flag of that source once the edge has been processed.
    task automatic pulse(input int s, output logic ovf_out);
        src[s] = 1'b1;
        step(1);
        src[s] = 1'b0;
        step(2);
        ovf_out = ovf[s];
        step(1);
    endtask

    task automatic claim_one(input int s);
        claim[s] = 1'b1;
        step(1);
        claim[s] = 1'b0;
    endtask

    task automatic complete_one(input int s);
        cmpl[s] = 1'b1;
        step(1);
        cmpl[s] = 1'b0;
    endtask

    initial begin
        rstn  = 1'b0;
        src   = '0;
        mode  = 8'b0000_0110;
        claim = '0;
        cmpl  = '0;
        step(3);
        check_eq("reset_req", 32'(req), 32'h0);
        check_eq("reset_ovf", 32'(ovf), 32'h0);
        rstn = 1'b1;
        step(2);

        // Level source 0
        src[0] = 1'b1;
        step(2);
        check_eq("lvl_req_early", 32'(req[0]), 32'h0);
        step(1);
        check_eq("lvl_req_lat3", 32'(req[0]), 32'h1);
        claim_one(0);
        check_eq("lvl_claimed", 32'(req[0]), 32'h0);
        complete_one(0);
        check_eq("lvl_rereq", 32'(req[0]), 32'h1);
        claim_one(0);
        src[0] = 1'b0;
        step(3);
        check_eq("lvl_inserv", 32'(req[0]), 32'h0);
        complete_one(0);
        check_eq("lvl_idle", 32'(req[0]), 32'h0);
        step(2);
        check_eq("lvl_idle_hold", 32'(req[0]), 32'h0);

        // Edge source 1: three edges, three service rounds
        for (int k = 0; k < 3; k++) pulse(1, ov);
        check_eq("edge_req", 32'(req[1]), 32'h1);
        check_eq("edge_cnt3", 32'(dut.g_src[1].u_cell.cnt_q), 32'd3);
        for (int r = 0; r < 3; r++) begin
            claim_one(1);
            check_eq("edge_claim_req", 32'(req[1]), 32'h0);
            check_eq("edge_claim_cnt", 32'(dut.g_src[1].u_cell.cnt_q), 32'(2 - r));
            complete_one(1);
            check_eq("edge_round_req", 32'(req[1]), (r < 2) ? 32'h1 : 32'h0);
        end
        check_eq("edge_cnt0", 32'(dut.g_src[1].u_cell.cnt_q), 32'd0);

        // Saturation: nine edges, no claim
        for (int k = 0; k < 9; k++) begin
            pulse(1, ov);
            ov_seen[k] = ov;
        end
        check_eq("sat_ovf_pattern", 32'(ov_seen), 32'h180);
        check_eq("sat_ovf_cleared", 32'(ovf[1]), 32'h0);
        check_eq("sat_cnt7", 32'(dut.g_src[1].u_cell.cnt_q), 32'd7);

        // Edge coinciding with accepted claim at saturation
        src[1] = 1'b1;
        step(1);
        src[1] = 1'b0;
        step(1);
        claim_one(1);
        check_eq("sim_cnt_same", 32'(dut.g_src[1].u_cell.cnt_q), 32'd7);
        check_eq("sim_no_ovf", 32'(ovf[1]), 32'h0);
        check_eq("sim_inserv", 32'(req[1]), 32'h0);
        complete_one(1);
        check_eq("sim_rereq", 32'(req[1]), 32'h1);
        claim[1] = 1'b1;
        cmpl[1]  = 1'b1;
        step(1);
        claim[1] = 1'b0;
        cmpl[1]  = 1'b0;
        check_eq("cc_inserv", 32'(req[1]), 32'h0);
        check_eq("cc_cnt6", 32'(dut.g_src[1].u_cell.cnt_q), 32'd6);
        step(2);
        check_eq("cc_still_inserv", 32'(req[1]), 32'h0);
        complete_one(1);
        check_eq("cc_rereq", 32'(req[1]), 32'h1);

        // Reset in the middle of service on source 2
        for (int k = 0; k < 5; k++) pulse(2, ov);
        claim_one(2);
        check_eq("rst_pre_state", 32'(dut.g_src[2].u_cell.state_q), 32'd2);
        check_eq("rst_pre_cnt", 32'(dut.g_src[2].u_cell.cnt_q), 32'd4);
        #3;
        rstn = 1'b0;
        #1;
        check_eq("rst_async_req", 32'(req), 32'h0);
        check_eq("rst_async_cnt2", 32'(dut.g_src[2].u_cell.cnt_q), 32'd0);
        check_eq("rst_async_cnt1", 32'(dut.g_src[1].u_cell.cnt_q), 32'd0);
        step(2);
        rstn = 1'b1;
        step(6);
        check_eq("rst_after_req", 32'(req), 32'h0);

        // Mode change on source 3 while in service
        src[3] = 1'b1;
        step(3);
        check_eq("mode_lvl_req", 32'(req[3]), 32'h1);
        claim_one(3);
        mode[3] = 1'b1;
        complete_one(3);
        check_eq("mode_frozen_lvl", 32'(req[3]), 32'h1);
        claim_one(3);
        src[3] = 1'b0;
        step(3);
        complete_one(3);
        check_eq("mode_idle", 32'(req[3]), 32'h0);
        step(1);
        src[3] = 1'b1;
        step(4);
        check_eq("mode_edge_req", 32'(req[3]), 32'h1);
        check_eq("mode_edge_cnt", 32'(dut.g_src[3].u_cell.cnt_q), 32'd1);
        claim_one(3);
        step(2);
        complete_one(3);
        check_eq("mode_edge_norereq", 32'(req[3]), 32'h0);
        src[3] = 1'b0;
        step(3);

        // All sources at once
        mode = 8'hF0;
        step(1);
        src = 8'hFF;
        step(1);
        src = 8'h00;
        step(3);
        check_eq("all_req", 32'(req), 32'hFF);
        claim = 8'h55;
        step(1);
        claim = 8'h00;
        check_eq("all_claim55", 32'(req), 32'hAA);
        cmpl = 8'hFF;
        step(1);
        cmpl = 8'h00;
        check_eq("all_cmpl", 32'(req), 32'hAA);
        check_eq("all_cnt5", 32'(dut.g_src[5].u_cell.cnt_q), 32'd1);
        check_eq("all_cnt4", 32'(dut.g_src[4].u_cell.cnt_q), 32'd0);
        claim = 8'hAA;
        step(1);
        claim = 8'h00;
        check_eq("all_claimAA", 32'(req), 32'h00);
        cmpl = 8'hAA;
        step(1);
        cmpl = 8'h00;
        check_eq("all_idle", 32'(req), 32'h00);
        check_eq("all_no_ovf", 32'(ovf), 32'h00);
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
